// File: rtl/fu_pkg.sv
// fu_pkg: shared constants for the execute-stage function units
package fu_pkg;
  localparam int FU_WIDTH = 8;
  localparam int CNT_W = 3;
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [FU_WIDTH-1:0] DIV_ZERO_QUOT = 8'hFF;
endpackage

// File: rtl/fu_sub8.sv
// fu_sub8: combinational 8-bit subtractor, din1 + ~din2 + 1
module fu_sub8 import fu_pkg::*; (
  input  logic [FU_WIDTH-1:0] din1,
  input  logic [FU_WIDTH-1:0] din2,
  output logic [FU_WIDTH-1:0] dout,
  output logic                borrow_out
);
  logic carry;
  assign {carry, dout} = {1'b0, din1} + {1'b0, ~din2} + {{FU_WIDTH{1'b0}}, 1'b1};
  assign borrow_out = ~carry;
endmodule

// File: rtl/fu_div8.sv
// fu_div8: iterative restoring divider, one quotient bit per clock, signed/unsigned
module fu_div8 import fu_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sign,
  input  logic [FU_WIDTH-1:0] din1,
  input  logic [FU_WIDTH-1:0] din2,
  output logic [FU_WIDTH-1:0] quot,
  output logic [FU_WIDTH-1:0] rem,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [FU_WIDTH-1:0] p, q, d, diff;
  logic [FU_WIDTH:0] t;
  logic neg_q, neg_r, borrow, take;
  assign t = {p, q[FU_WIDTH-1]};
  // T[8] set means T already exceeds any 8-bit divisor
  assign take = t[FU_WIDTH] | ~borrow;
  fu_sub8 u_sub (.din1(t[FU_WIDTH-1:0]), .din2(d), .dout(diff), .borrow_out(borrow));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt <= '0;
      p <= '0;
      q <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quot <= '0;
      rem <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DIV_IDLE) begin
        if (start && din2 == '0) begin
          quot <= DIV_ZERO_QUOT;
          rem <= din1;
          div_zero <= 1'b1;
          done <= 1'b1;
        end else if (start) begin
          neg_q <= sign & (din1[FU_WIDTH-1] ^ din2[FU_WIDTH-1]);
          neg_r <= sign & din1[FU_WIDTH-1];
          q <= (sign & din1[FU_WIDTH-1]) ? -din1 : din1;
          d <= (sign & din2[FU_WIDTH-1]) ? -din2 : din2;
          p <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= DIV_CALC;
        end
      end else if (state == DIV_CALC) begin
        p <= take ? diff : t[FU_WIDTH-1:0];
        q <= {q[FU_WIDTH-2:0], take};
        cnt <= cnt + 1'b1;
        state <= (cnt == CNT_W'(FU_WIDTH - 1)) ? DIV_FIX : DIV_CALC;
      end else begin
        quot <= neg_q ? -q : q;
        rem <= neg_r ? -p : p;
        div_zero <= 1'b0;
        done <= (state == DIV_FIX);
        busy <= 1'b0;
        state <= DIV_IDLE;
      end
    end
  end
endmodule
